// File: rtl/xover_biquad_engine.sv
// Time-multiplexed DF-I biquad crossover: one shared MAC walks every
// (channel, band, stage) section per frame, using double-buffered coefficients.
module xover_biquad_engine #(
    parameter int NCH         = 2,
    parameter int NBAND       = 2,
    parameter int NSTAGE      = 2,
    parameter int DATA_NBITS  = 24,
    parameter int COEFF_NBITS = 32,
    parameter int COEFF_FRAC  = 30,
    parameter int ACC_NBITS   = 64,
    localparam int CA_NBITS   = $clog2(NBAND*NSTAGE*5)
) (
    input  logic                              i_mck,
    input  logic                              i_rstn,
    input  logic                              i_sample_valid,
    input  logic [NCH*DATA_NBITS-1:0]         i_data,
    output logic [NCH*NBAND*DATA_NBITS-1:0]   o_data,
    output logic                              o_sample_valid,
    output logic                              o_busy,
    output logic                              o_overrun,
    input  logic                              i_coef_we,
    input  logic [CA_NBITS-1:0]               i_coef_addr,
    input  logic [COEFF_NBITS-1:0]            i_coef_data,
    input  logic                              i_coef_commit,
    output logic                              o_coef_pending
);
    localparam int NSEC   = NCH*NBAND*NSTAGE;
    localparam int NCOEF  = NBAND*NSTAGE*5;
    localparam int NSLOT  = NCH*NBAND;
    localparam int SEC_W  = (NSEC   > 1) ? $clog2(NSEC)   : 1;
    localparam int SLOT_W = (NSLOT  > 1) ? $clog2(NSLOT)  : 1;
    localparam int CH_W   = (NCH    > 1) ? $clog2(NCH)    : 1;
    localparam int BAND_W = (NBAND  > 1) ? $clog2(NBAND)  : 1;
    localparam int STG_W  = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam int PW     = COEFF_NBITS + DATA_NBITS;

    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NCH-1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NBAND-1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(NSTAGE-1);
    localparam logic signed [ACC_NBITS-1:0] SAT_MAX = ACC_NBITS'(2**(DATA_NBITS-1) - 1);
    localparam logic signed [ACC_NBITS-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WB, S_DONE} state_t;

    state_t                         r_state;
    logic [2:0]                     r_k;
    logic [CH_W-1:0]                r_ch;
    logic [BAND_W-1:0]              r_band;
    logic [STG_W-1:0]               r_stage;
    logic signed [ACC_NBITS-1:0]    r_acc;
    logic signed [DATA_NBITS-1:0]   r_prev_y;
    logic signed [DATA_NBITS-1:0]   r_sample    [NCH];
    logic signed [COEFF_NBITS-1:0]  r_shadow    [NCOEF];
    logic signed [COEFF_NBITS-1:0]  r_active    [NCOEF];
    logic signed [DATA_NBITS-1:0]   r_x1 [NSEC];
    logic signed [DATA_NBITS-1:0]   r_x2 [NSEC];
    logic signed [DATA_NBITS-1:0]   r_y1 [NSEC];
    logic signed [DATA_NBITS-1:0]   r_y2 [NSEC];
    logic signed [DATA_NBITS-1:0]   r_stage_out [NSLOT];
    logic [NCH*NBAND*DATA_NBITS-1:0] r_data;
    logic                           r_sample_valid;
    logic                           r_busy;
    logic                           r_overrun;
    logic                           r_pending;

    logic [SEC_W-1:0]               w_sec;
    logic [CA_NBITS-1:0]            w_cidx;
    logic [SLOT_W-1:0]              w_slot;
    logic signed [DATA_NBITS-1:0]   w_x;
    logic signed [DATA_NBITS-1:0]   w_opd;
    logic signed [COEFF_NBITS-1:0]  w_coef;
    logic signed [PW-1:0]           w_prod;
    logic signed [ACC_NBITS-1:0]    w_prod_ext;
    logic signed [ACC_NBITS-1:0]    w_shift;
    logic signed [DATA_NBITS-1:0]   w_y;
    logic                           w_last_sec;

    assign w_sec  = SEC_W'((32'(r_ch)*NBAND + 32'(r_band))*NSTAGE + 32'(r_stage));
    assign w_cidx = CA_NBITS'((32'(r_band)*NSTAGE + 32'(r_stage))*5 + 32'(r_k));
    assign w_slot = SLOT_W'(32'(r_ch)*NBAND + 32'(r_band));
    // Later stages are fed by the saturated result of the stage just written back.
    assign w_x    = (r_stage == '0) ? r_sample[r_ch] : r_prev_y;
    assign w_coef = r_active[w_cidx];
    assign w_last_sec = (r_ch == CH_LAST) && (r_band == BAND_LAST) && (r_stage == STG_LAST);

    always_comb begin
        w_opd = '0;
        case (r_k)
            3'd0:    w_opd = w_x;
            3'd1:    w_opd = r_x1[w_sec];
            3'd2:    w_opd = r_x2[w_sec];
            3'd3:    w_opd = r_y1[w_sec];
            3'd4:    w_opd = r_y2[w_sec];
            default: w_opd = '0;
        endcase
    end

    assign w_prod     = w_coef * w_opd;
    assign w_prod_ext = {{(ACC_NBITS-PW){w_prod[PW-1]}}, w_prod};
    assign w_shift    = r_acc >>> COEFF_FRAC;

    always_comb begin
        w_y = w_shift[DATA_NBITS-1:0];
        if (w_shift > SAT_MAX)
            w_y = SAT_MAX[DATA_NBITS-1:0];
        else if (w_shift < SAT_MIN)
            w_y = SAT_MIN[DATA_NBITS-1:0];
    end

    always_ff @(posedge i_mck or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state        <= S_IDLE;
            r_k            <= '0;
            r_ch           <= '0;
            r_band         <= '0;
            r_stage        <= '0;
            r_acc          <= '0;
            r_prev_y       <= '0;
            r_data         <= '0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_pending      <= 1'b0;
            for (int i = 0; i < NCH; i++)   r_sample[i] <= '0;
            for (int i = 0; i < NSLOT; i++) r_stage_out[i] <= '0;
            for (int i = 0; i < NCOEF; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            for (int i = 0; i < NSEC; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            r_overrun      <= i_sample_valid && (r_state != S_IDLE);
            r_sample_valid <= 1'b0;
            if (i_coef_we && (i_coef_addr < CA_NBITS'(NCOEF)))
                r_shadow[i_coef_addr] <= i_coef_data;
            // A commit arriving on the copy cycle must survive to the next frame.
            if (i_coef_commit)
                r_pending <= 1'b1;
            else if (r_state == S_LOAD)
                r_pending <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_sample_valid) begin
                        for (int c = 0; c < NCH; c++)
                            r_sample[c] <= i_data[c*DATA_NBITS +: DATA_NBITS];
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (r_pending)
                        for (int i = 0; i < NCOEF; i++) r_active[i] <= r_shadow[i];
                    r_k     <= '0;
                    r_ch    <= '0;
                    r_band  <= '0;
                    r_stage <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    if (r_k == 3'd0)
                        r_acc <= w_prod_ext;
                    else if (r_k < 3'd3)
                        r_acc <= r_acc + w_prod_ext;
                    else
                        r_acc <= r_acc - w_prod_ext;
                    if (r_k == 3'd4) begin
                        r_k     <= '0;
                        r_state <= S_WB;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                S_WB: begin
                    r_x2[w_sec] <= r_x1[w_sec];
                    r_x1[w_sec] <= w_x;
                    r_y2[w_sec] <= r_y1[w_sec];
                    r_y1[w_sec] <= w_y;
                    r_prev_y    <= w_y;
                    if (r_stage == STG_LAST)
                        r_stage_out[w_slot] <= w_y;
                    if (r_stage != STG_LAST) begin
                        r_stage <= r_stage + STG_W'(1);
                    end else begin
                        r_stage <= '0;
                        if (r_band != BAND_LAST) begin
                            r_band <= r_band + BAND_W'(1);
                        end else begin
                            r_band <= '0;
                            r_ch   <= r_ch + CH_W'(1);
                        end
                    end
                    r_state <= w_last_sec ? S_DONE : S_MAC;
                end
                S_DONE: begin
                    for (int s = 0; s < NSLOT; s++)
                        r_data[s*DATA_NBITS +: DATA_NBITS] <= r_stage_out[s];
                    r_sample_valid <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data         = r_data;
    assign o_sample_valid = r_sample_valid;
    assign o_busy         = r_busy;
    assign o_overrun      = r_overrun;
    assign o_coef_pending = r_pending;
endmodule

// File: tb/tb_xover_biquad_engine.sv
// Bench for xover_biquad_engine: a frame-level arithmetic model feeds a per-cycle
// checker, while literal expectations pin both the DUT and the model.
module tb_xover_biquad_engine;
    logic        i_mck = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_sample_valid = 1'b0;
    logic [47:0] i_data = '0;
    logic [95:0] o_data;
    logic        o_sample_valid;
    logic        o_busy;
    logic        o_overrun;
    logic        i_coef_we = 1'b0;
    logic [4:0]  i_coef_addr = '0;
    logic [31:0] i_coef_data = '0;
    logic        i_coef_commit = 1'b0;
    logic        o_coef_pending;

    xover_biquad_engine dut (
        .i_mck(i_mck), .i_rstn(i_rstn), .i_sample_valid(i_sample_valid),
        .i_data(i_data), .o_data(o_data), .o_sample_valid(o_sample_valid),
        .o_busy(o_busy), .o_overrun(o_overrun), .i_coef_we(i_coef_we),
        .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
        .i_coef_commit(i_coef_commit), .o_coef_pending(o_coef_pending)
    );

    always #5 i_mck = ~i_mck;

    int cyc = 0;
    always @(posedge i_mck) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Frame-level model state
    int          shadow [20];
    int          active [20];
    int          hx1 [8], hx2 [8], hy1 [8], hy2 [8];
    bit          pend;
    logic [95:0] held, frame_out;
    int          acc_cyc = -1000;
    int          exp_valid_cyc = -1;
    int          exp_ovr_cyc = -1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int sx24(input int v);
        return (v <<< 8) >>> 8;
    endfunction

    function automatic int sat24(input longint v);
        if (v > 64'sd8388607) return 8388607;
        if (v < -64'sd8388608) return -8388608;
        return int'(v);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 20; i++) begin shadow[i] = 0; active[i] = 0; end
        for (int i = 0; i < 8; i++) begin hx1[i] = 0; hx2[i] = 0; hy1[i] = 0; hy2[i] = 0; end
        pend = 0; held = '0; frame_out = '0;
        acc_cyc = -1000; exp_valid_cyc = -1; exp_ovr_cyc = -1;
    endtask

    task automatic model_frame(input int s0, input int s1);
        int     xin, y, sec, cb;
        longint acc;
        if (pend) begin
            for (int i = 0; i < 20; i++) active[i] = shadow[i];
            pend = 0;
        end
        for (int c = 0; c < 2; c++)
            for (int b = 0; b < 2; b++) begin
                xin = sx24(c == 0 ? s0 : s1);
                for (int s = 0; s < 2; s++) begin
                    sec = (c*2 + b)*2 + s;
                    cb  = (b*2 + s)*5;
                    acc = longint'(active[cb])   * xin      + longint'(active[cb+1]) * hx1[sec]
                        + longint'(active[cb+2]) * hx2[sec] - longint'(active[cb+3]) * hy1[sec]
                        - longint'(active[cb+4]) * hy2[sec];
                    y = sat24(acc >>> 30);
                    hx2[sec] = hx1[sec]; hx1[sec] = xin;
                    hy2[sec] = hy1[sec]; hy1[sec] = y;
                    xin = y;
                end
                frame_out[(c*2 + b)*24 +: 24] = xin[23:0];
            end
    endtask

    // Per-cycle compare against the model
    always @(negedge i_mck) begin
        logic exp_v;
        exp_v = (cyc == exp_valid_cyc);
        if (exp_v) held = frame_out;
        chk("valid",   {127'd0, o_sample_valid}, {127'd0, exp_v});
        chk("odata",   {32'd0, o_data}, {32'd0, held});
        chk("busy",    {127'd0, o_busy}, {127'd0, (cyc >= acc_cyc) && (cyc <= acc_cyc + 49)});
        chk("overrun", {127'd0, o_overrun}, {127'd0, cyc == exp_ovr_cyc});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_mck);
        #1;
    endtask

    task automatic send(input int d0, input int d1);
        int e;
        i_sample_valid = 1'b1;
        i_data = {d1[23:0], d0[23:0]};
        e = cyc + 1;
        if ((cyc >= acc_cyc) && (cyc <= acc_cyc + 49)) begin
            exp_ovr_cyc = e;
            $display("frame ch0=%06h ch1=%06h dropped (busy) at cycle %0d", d0[23:0], d1[23:0], e);
        end else begin
            acc_cyc = e;
            exp_valid_cyc = e + 50;
            model_frame(d0, d1);
            $display("frame ch0=%06h ch1=%06h accepted at cycle %0d, expect %h", d0[23:0], d1[23:0], e, frame_out);
        end
        tick(1);
        i_sample_valid = 1'b0;
        i_data = 48'({$urandom(), $urandom()});
    endtask

    task automatic wr(input int addr, input logic [31:0] val);
        i_coef_we = 1'b1;
        i_coef_addr = addr[4:0];
        i_coef_data = val;
        shadow[addr] = int'(val);
        tick(1);
        i_coef_we = 1'b0;
    endtask

    task automatic commit();
        i_coef_commit = 1'b1;
        pend = 1;
        tick(1);
        i_coef_commit = 1'b0;
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        model_clear();
        tick(2);
        i_rstn = 1'b1;
        tick(1);
    endtask

    task automatic set_b0_all(input logic [31:0] val);
        for (int s = 0; s < 4; s++) wr(s*5, val);
    endtask

    int lp_exp [4] = '{32'h100000, 32'h080000, 32'h040000, 32'h020000};
    int hp_exp [4] = '{32'h100000, 32'h0, 32'h0, 32'h0};

    initial begin
        model_clear();
        tick(3);
        i_rstn = 1'b1;
        tick(2);

        // 1: reset mid-frame, then a frame with cleared coefficients
        set_b0_all(32'h40000000);
        commit();
        send(32'h123456, 32'h0F0000);
        tick(20);
        i_rstn = 1'b0;
        model_clear();
        #2;
        chk("t1_busy_rst", {127'd0, o_busy}, 128'd0);
        chk("t1_data_rst", {32'd0, o_data}, 128'd0);
        chk("t1_pend_rst", {127'd0, o_coef_pending}, 128'd0);
        tick(2);
        i_rstn = 1'b1;
        tick(1);
        send(32'h123456, 32'h0F0000);
        tick(55);
        chk("t1_zero_out", {32'd0, o_data}, 128'd0);

        // 2: passthrough
        set_b0_all(32'h40000000);
        commit();
        chk("t2_pend_set", {127'd0, o_coef_pending}, 128'd1);
        send(32'h123456, 32'hF00000);
        tick(2);
        chk("t2_pend_clr", {127'd0, o_coef_pending}, 128'd0);
        tick(53);
        chk("t2_pass", {32'd0, o_data}, {32'd0, 96'hF00000_F00000_123456_123456});
        chk("t2_model", {32'd0, held}, {32'd0, 96'hF00000_F00000_123456_123456});

        // 3: overrun
        send(32'h654321, 32'h000010);
        tick(9);
        send(32'h111111, 32'h222222);
        tick(50);
        chk("t3_hold", {32'd0, o_data}, {32'd0, 96'h000010_000010_654321_654321});

        // 4: saturation
        set_b0_all(32'h7FFFFFFF);
        commit();
        send(32'h600000, 32'hA00000);
        tick(55);
        chk("t4_sat", {32'd0, o_data}, {32'd0, 96'h800000_800000_7FFFFF_7FFFFF});

        // 5: recursion in band 0 stage 0
        do_reset();
        set_b0_all(32'h40000000);
        wr(3, 32'hE0000000);
        commit();
        for (int i = 0; i < 4; i++) begin
            send(i == 0 ? 32'h100000 : 0, 0);
            tick(55);
            chk("t5_lp", {104'd0, o_data[23:0]}, 128'(lp_exp[i]));
            chk("t5_hp", {104'd0, o_data[47:24]}, 128'(hp_exp[i]));
            chk("t5_ch1", {80'd0, o_data[95:48]}, 128'd0);
            chk("t5_model", {104'd0, held[23:0]}, 128'(lp_exp[i]));
        end

        // 6: coefficient update during a frame only applies to the next one
        do_reset();
        set_b0_all(32'h40000000);
        commit();
        send(32'h100000, 32'h100000);
        set_b0_all(32'h20000000);
        commit();
        tick(50);
        chk("t6_old", {32'd0, o_data}, {32'd0, 96'h100000_100000_100000_100000});
        chk("t6_pend", {127'd0, o_coef_pending}, 128'd1);
        send(32'h100000, 32'h100000);
        tick(55);
        chk("t6_new", {32'd0, o_data}, {32'd0, 96'h040000_040000_040000_040000});
        chk("t6_pend_clr", {127'd0, o_coef_pending}, 128'd0);

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
